// File: rtl/branch_comp_seq.sv
// Multi-cycle branch comparator: compares rs1/rs2 MSB-first, CHUNK bits per cycle,
// and resolves RV32I branch conditions. Optional macro: BRCOMP_EARLY_EXIT_EN.
module branch_comp_seq #(
  parameter int XLEN  = 32,
  parameter int CHUNK = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      funct3,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            br_eq,
  output logic            br_lt,
  output logic            br_taken,
  output logic            br_illegal
);

  localparam int NCHUNK = XLEN / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state, stateNext;

  logic [CNT_W-1:0] cnt, cntNext;
  logic             decided, decidedNext;
  logic             ltQ, ltNext;
  logic [XLEN-1:0]  opA, opB;
  logic [2:0]       f3Q;
  logic [CHUNK-1:0] chunkA, chunkB;
  logic             accept, finish;

  function automatic logic takenFn(input logic [2:0] f3, input logic eq, input logic lt);
    logic t;
    case (f3)
      3'b000:         t = eq;
      3'b001:         t = !eq;
      3'b100, 3'b110: t = lt;
      3'b101, 3'b111: t = !lt;
      default:        t = 1'b0;
    endcase
    return t;
  endfunction

  function automatic logic illegalFn(input logic [2:0] f3);
    return (f3[2:1] == 2'b01);
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext   = state;
    cntNext     = cnt;
    decidedNext = decided;
    ltNext      = ltQ;
    accept      = 1'b0;
    finish      = 1'b0;
    chunkA      = opA[XLEN-1 -: CHUNK];
    chunkB      = opB[XLEN-1 -: CHUNK];
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept      = 1'b1;
          stateNext   = BUSY;
          cntNext     = '0;
          decidedNext = 1'b0;
          ltNext      = 1'b0;
        end
      end
      BUSY: begin
        cntNext = cnt + CNT_W'(1);
        // First differing chunk decides the ordering; later chunks are ignored.
        if (!decided && (chunkA != chunkB)) begin
          decidedNext = 1'b1;
          ltNext      = (chunkA < chunkB);
        end
        if (cnt == LAST_CNT) begin
          finish = 1'b1;
        end
`ifdef BRCOMP_EARLY_EXIT_EN
        if (decidedNext) begin
          finish = 1'b1;
        end
`endif
        if (finish) begin
          stateNext = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Control and result registers; results persist after the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      decided    <= 1'b0;
      ltQ        <= 1'b0;
      br_eq      <= 1'b0;
      br_lt      <= 1'b0;
      br_taken   <= 1'b0;
      br_illegal <= 1'b0;
    end else begin
      cnt     <= cntNext;
      decided <= decidedNext;
      ltQ     <= ltNext;
      if (finish) begin
        br_eq      <= !decidedNext;
        br_lt      <= ltNext;
        br_taken   <= takenFn(f3Q, !decidedNext, ltNext);
        br_illegal <= illegalFn(f3Q);
      end
    end
  end

  // Operand shift registers; flipping the MSB in signed mode lets one unsigned compare serve both.
  always_ff @(posedge clk) begin
    if (accept) begin
      opA <= rs1 ^ {~funct3[1], {(XLEN-1){1'b0}}};
      opB <= rs2 ^ {~funct3[1], {(XLEN-1){1'b0}}};
      f3Q <= funct3;
    end else if (state == BUSY) begin
      opA <= opA << CHUNK;
      opB <= opB << CHUNK;
    end
  end

endmodule

// File: tb/tb_branch_comp_seq.sv
// Scoreboard bench for branch_comp_seq: randomized requests, a behavioural model,
// and a monitor that checks results, latency and backpressure stability.
module tb_branch_comp_seq;
  localparam int XLEN   = 32;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = XLEN / CHUNK;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] rs1, rs2;
  logic [2:0]      funct3;
  logic            out_valid;
  logic            out_ready;
  logic            br_eq, br_lt, br_taken, br_illegal;

  branch_comp_seq #(.XLEN(XLEN), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rs1(rs1), .rs2(rs2), .funct3(funct3), .out_valid(out_valid),
    .out_ready(out_ready), .br_eq(br_eq), .br_lt(br_lt),
    .br_taken(br_taken), .br_illegal(br_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic eq;
    logic lt;
    logic taken;
    logic ill;
    int   acc;
    int   lat;
  } exp_t;

  exp_t expQ[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  int   forceMode  = 2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic failNow(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  function automatic exp_t model(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                 input logic [2:0] f3, input int acc);
    exp_t e;
    logic [XLEN-1:0] d;
    int hb;
    e.eq  = (a == b);
    e.lt  = f3[1] ? (a < b) : ($signed(a) < $signed(b));
    e.ill = (f3 == 3'd2) || (f3 == 3'd3);
    case (f3)
      3'd0:       e.taken = e.eq;
      3'd1:       e.taken = !e.eq;
      3'd4, 3'd6: e.taken = e.lt;
      3'd5, 3'd7: e.taken = !e.lt;
      default:    e.taken = 1'b0;
    endcase
    e.acc = acc;
    e.lat = NCHUNK;
`ifdef BRCOMP_EARLY_EXIT_EN
    if (a != b) begin
      d  = a ^ b;
      hb = 0;
      for (int i = XLEN - 1; i >= 0; i--) begin
        if (d[i]) begin
          hb = i;
          break;
        end
      end
      e.lat = (XLEN - 1 - hb) / CHUNK + 1;
    end
`else
    d  = '0;
    hb = 0;
`endif
    return e;
  endfunction

  task automatic send(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                      input logic [2:0] f3, input bit push);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      failNow("in_ready_timeout");
      return;
    end
    rs1      = a;
    rs2      = b;
    funct3   = f3;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (push) expQ.push_back(model(a, b, f3, cyc));
  endtask

  task automatic waitIdle();
    int n = 0;
    while ((!in_ready || expQ.size() != 0) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) failNow("idle_timeout");
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (forceMode)
        1:       out_ready = 1'b0;
        2:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(3) != 0);
      endcase
    end
  end

  // Monitor: pops one expectation per result, then checks it stays put until taken.
  initial begin
    bit   active = 0;
    exp_t e;
    logic [3:0] snap;
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 0;
      end else if (out_valid) begin
        if (!active) begin
          if (expQ.size() == 0) begin
            failNow("unexpected_out_valid");
          end else begin
            e = expQ.pop_front();
            check("br_eq", br_eq, e.eq);
            check("br_lt", br_lt, e.lt);
            check("br_taken", br_taken, e.taken);
            check("br_illegal", br_illegal, e.ill);
            check("latency", cyc - e.acc, e.lat);
            check("in_ready_done", in_ready, 1'b0);
          end
          snap   = {br_eq, br_lt, br_taken, br_illegal};
          active = 1;
        end else begin
          check("hold_outputs", {br_eq, br_lt, br_taken, br_illegal}, snap);
          check("hold_in_ready", in_ready, 1'b0);
        end
        if (out_ready) active = 0;
      end
    end
  end

  initial begin
    int n;
    int hs;
    logic [XLEN-1:0] a, b;
    rst      = 1'b1;
    in_valid = 1'b0;
    rs1      = '0;
    rs2      = '0;
    funct3   = '0;
    #12;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_br_eq", br_eq, 1'b0);
    check("rst_br_lt", br_lt, 1'b0);
    check("rst_br_taken", br_taken, 1'b0);
    check("rst_br_illegal", br_illegal, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed cases
    forceMode = 2;
    send(32'h1234_5678, 32'h1234_5678, 3'b000, 1);
    send(32'hFFFF_FFFF, 32'h0000_0001, 3'b100, 1);
    send(32'hFFFF_FFFF, 32'h0000_0001, 3'b110, 1);
    send(32'h8000_0000, 32'h7FFF_FFFF, 3'b101, 1);
    send(32'h8000_0000, 32'h7FFF_FFFF, 3'b111, 1);
    send(32'h0100_0000, 32'h0200_0000, 3'b110, 1);
    send(32'h0100_0000, 32'h0200_0000, 3'b010, 1);
    send(32'h0000_0005, 32'h0000_0005, 3'b011, 1);
    send(32'h0000_0005, 32'h0000_0006, 3'b001, 1);
    send(32'h7FFF_FFFF, 32'h8000_0000, 3'b111, 1);

    // Backpressure: hold out_ready low, then release and re-issue immediately
    waitIdle();
    forceMode = 1;
    @(posedge clk);
    #2;
    send(32'h0000_00AA, 32'h0000_00AB, 3'b110, 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 40);
    if (!out_valid) failNow("bp_out_valid_timeout");
    repeat (5) @(negedge clk);
    forceMode = 2;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("bp_idle_in_ready", in_ready, 1'b1);
    check("bp_idle_out_valid", out_valid, 1'b0);
    hs = cyc;
    send(32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'b001, 1);
    check("bp_accept_edge", cyc, hs + 1);
    check("bp_busy_in_ready", in_ready, 1'b0);

    // Reset mid-operation: request dropped, registers cleared
    waitIdle();
    send(32'h1122_3344, 32'h1122_3344, 3'b000, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_br_eq", br_eq, 1'b0);
    check("midrst_br_taken", br_taken, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (NCHUNK + 3) @(negedge clk);
    #1;
    send(32'h0000_0010, 32'hFFFF_FFF0, 3'b100, 1);

    // Randomized traffic with random backpressure
    forceMode = 0;
    repeat (150) begin
      a = $urandom;
      case ($urandom_range(4))
        0:       b = a;
        1:       b = a ^ (32'h1 << $urandom_range(XLEN - 1));
        2:       b = {a[XLEN-1:CHUNK], 8'($urandom)};
        3:       b = ($urandom_range(1) != 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
        default: b = $urandom;
      endcase
      send(a, b, 3'($urandom_range(7)), 1);
    end

    n = 0;
    while ((expQ.size() != 0 || out_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (expQ.size() != 0) failNow("drain_timeout");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
